// File: rtl/tank_pkg.sv
// Types, type codes and the renderer state-word packer shared by the
// tank-war player and bullet blocks.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_HIT,
    ST_RESPAWN,
    ST_DEAD
  } tank_st_t;

  localparam logic [1:0] OBJ_TANK = 2'd1;

  function automatic logic [31:0] pack_state(
    input logic [1:0] obj,
    input logic       active,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [1:0] dir,
    input logic [2:0] row,
    input logic [2:0] col
  );
    return {1'b0, obj, active, x, y, dir, row, col};
  endfunction

endpackage

// File: rtl/tile_probe.sv
// Combinational tile-map probe: decides whether a TILE_W square placed at a
// candidate position would leave the map or touch a solid tile on its leading edge.
module tile_probe
  import tank_pkg::*;
#(
  parameter int TILE_W = 32,
  parameter int MAP_W  = 16,
  parameter int MAP_H  = 16,
  parameter int POS_W  = 10
) (
  input  logic signed [POS_W:0]     cand_x,
  input  logic signed [POS_W:0]     cand_y,
  input  dir_t                      dir,
  input  logic [MAP_W*MAP_H-1:0]    wall_map,
  output logic                      blocked
);

  localparam int SHIFT = $clog2(TILE_W);
  localparam int IDX_W = (MAP_W * MAP_H > 1) ? $clog2(MAP_W * MAP_H) : 1;

  int               cx, cy, ax, ay, bx, by;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             out_of_map;

  // Corners a and b are the two pixels on the edge facing the direction of travel.
  always_comb begin
    cx = int'(cand_x);
    cy = int'(cand_y);
    ax = cx;
    ay = cy;
    bx = cx;
    by = cy;
    case (dir)
      DIR_LEFT:  by = cy + TILE_W - 1;
      DIR_RIGHT: begin
        ax = cx + TILE_W - 1;
        bx = cx + TILE_W - 1;
        by = cy + TILE_W - 1;
      end
      DIR_UP:    bx = cx + TILE_W - 1;
      default:   begin
        ay = cy + TILE_W - 1;
        by = cy + TILE_W - 1;
        bx = cx + TILE_W - 1;
      end
    endcase
    out_of_map = (cx < 0) || (cy < 0) ||
                 (cx + TILE_W > MAP_W * TILE_W) ||
                 (cy + TILE_W > MAP_H * TILE_W);
    idx_a   = IDX_W'((ay >> SHIFT) * MAP_W + (ax >> SHIFT));
    idx_b   = IDX_W'((by >> SHIFT) * MAP_W + (bx >> SHIFT));
    blocked = out_of_map || wall_map[idx_a] || wall_map[idx_b];
  end

endmodule

// File: rtl/tank_ctrl.sv
// Player tank controller: button-driven, map-checked motion, cooldown-limited
// bullet launches and the alive/hit/respawn/dead life cycle.
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int INIX         = 64,
  parameter int INIY         = 64,
  parameter int PLAYER_INDEX = int'(OBJ_TANK),
  parameter int TILE_W       = 32,
  parameter int MAP_W        = 16,
  parameter int MAP_H        = 16,
  parameter int POS_W        = 10,
  parameter int MOVE_TIME    = 800000,
  parameter int FIRE_TIME    = 800000,
  parameter int EXPLODE_TIME = 4000000,
  parameter int RESPAWN_TIME = 50000000,
  parameter int LIVES        = 3,
  parameter int ANIM_FRAMES  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         game_over,
  input  logic                         killed,
  input  logic [MAP_W*MAP_H-1:0]       wall_map,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         fire,
  output logic                         bullet_fire,
  output logic [1:0]                   bullet_direction,
  output logic [POS_W-1:0]             bullet_x,
  output logic [POS_W-1:0]             bullet_y,
  output logic [POS_W-1:0]             pos_x,
  output logic [POS_W-1:0]             pos_y,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic [31:0]                  tank_state
);

  localparam int LW      = $clog2(LIVES + 1);
  localparam int MW      = $clog2(MOVE_TIME + 1);
  localparam int FW      = $clog2(FIRE_TIME + 1);
  localparam int TMAX    = (EXPLODE_TIME > RESPAWN_TIME) ? EXPLODE_TIME : RESPAWN_TIME;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int QUARTER = EXPLODE_TIME / 4;

  localparam logic [POS_W-1:0]    SPAWN_X = POS_W'(INIX);
  localparam logic [POS_W-1:0]    SPAWN_Y = POS_W'(INIY);
  localparam logic [POS_W-1:0]    HALF    = POS_W'(TILE_W / 2);
  localparam logic signed [POS_W:0] ONE   = (POS_W+1)'(1);

  logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [POS_W-1:0] bullet_x_q, bullet_x_d, bullet_y_q, bullet_y_d;
  dir_t             dir_q, dir_d, bullet_dir_q, bullet_dir_d, btn_dir;
  tank_st_t         st_q, st_d;
  logic [2:0]       rom_row_q, rom_row_d, rom_col_q, rom_col_d;
  logic [LW-1:0]    lives_q, lives_d;
  logic [MW-1:0]    move_cnt_q, move_cnt_d;
  logic [FW-1:0]    fire_cnt_q, fire_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             bullet_fire_q, bullet_fire_d;
  logic             btn_any, blocked;
  logic signed [POS_W:0] cand_x, cand_y;

  function automatic logic [2:0] hit_frame(input logic [TW-1:0] t);
    if (int'(t) >= 3 * QUARTER)      return 3'd3;
    else if (int'(t) >= 2 * QUARTER) return 3'd2;
    else if (int'(t) >= QUARTER)     return 3'd1;
    else                             return 3'd0;
  endfunction

  // One extra sign bit keeps a step off the top/left edge negative.
  always_comb begin
    btn_any = left | right | up | down;
    btn_dir = DIR_DOWN;
    if (left)       btn_dir = DIR_LEFT;
    else if (right) btn_dir = DIR_RIGHT;
    else if (up)    btn_dir = DIR_UP;
    cand_x = $signed({1'b0, pos_x_q});
    cand_y = $signed({1'b0, pos_y_q});
    case (btn_dir)
      DIR_LEFT:  cand_x = cand_x - ONE;
      DIR_RIGHT: cand_x = cand_x + ONE;
      DIR_UP:    cand_y = cand_y - ONE;
      default:   cand_y = cand_y + ONE;
    endcase
  end

  tile_probe #(
    .TILE_W (TILE_W),
    .MAP_W  (MAP_W),
    .MAP_H  (MAP_H),
    .POS_W  (POS_W)
  ) u_probe (
    .cand_x   (cand_x),
    .cand_y   (cand_y),
    .dir      (btn_dir),
    .wall_map (wall_map),
    .blocked  (blocked)
  );

  always_comb begin
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    dir_d         = dir_q;
    st_d          = st_q;
    rom_row_d     = rom_row_q;
    rom_col_d     = rom_col_q;
    lives_d       = lives_q;
    move_cnt_d    = move_cnt_q;
    fire_cnt_d    = fire_cnt_q;
    timer_d       = timer_q;
    bullet_fire_d = 1'b0;
    bullet_dir_d  = bullet_dir_q;
    bullet_x_d    = bullet_x_q;
    bullet_y_d    = bullet_y_q;
    if (!game_over) begin
      if (move_cnt_q != '0) move_cnt_d = move_cnt_q - MW'(1);
      if (fire_cnt_q != '0) fire_cnt_d = fire_cnt_q - FW'(1);
      case (st_q)
        ST_ALIVE: begin
          if (killed) begin
            st_d      = ST_HIT;
            lives_d   = lives_q - LW'(1);
            timer_d   = '0;
            rom_row_d = 3'd4;
            rom_col_d = 3'd0;
          end else begin
            if (btn_any) begin
              dir_d = btn_dir;
              if (move_cnt_q == '0 && !blocked) begin
                pos_x_d    = cand_x[POS_W-1:0];
                pos_y_d    = cand_y[POS_W-1:0];
                move_cnt_d = MW'(MOVE_TIME - 1);
                rom_col_d  = (rom_col_q >= 3'(ANIM_FRAMES - 1)) ? 3'd0 : rom_col_q + 3'd1;
              end
            end
            rom_row_d = {1'b0, dir_d};
            if (fire && fire_cnt_q == '0) begin
              bullet_fire_d = 1'b1;
              bullet_dir_d  = dir_d;
              bullet_x_d    = pos_x_d + HALF;
              bullet_y_d    = pos_y_d + HALF;
              fire_cnt_d    = FW'(FIRE_TIME - 1);
            end
          end
        end
        ST_HIT: begin
          if (timer_q == TW'(EXPLODE_TIME - 1)) begin
            timer_d = '0;
            st_d    = (lives_q != '0) ? ST_RESPAWN : ST_DEAD;
          end else begin
            timer_d   = timer_q + TW'(1);
            rom_col_d = hit_frame(timer_d);
          end
        end
        ST_RESPAWN: begin
          if (timer_q == TW'(RESPAWN_TIME - 1)) begin
            st_d       = ST_ALIVE;
            timer_d    = '0;
            pos_x_d    = SPAWN_X;
            pos_y_d    = SPAWN_Y;
            dir_d      = DIR_LEFT;
            rom_row_d  = 3'd0;
            rom_col_d  = 3'd0;
            move_cnt_d = '0;
            fire_cnt_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_q       <= SPAWN_X;
      pos_y_q       <= SPAWN_Y;
      dir_q         <= DIR_LEFT;
      st_q          <= ST_ALIVE;
      rom_row_q     <= 3'd0;
      rom_col_q     <= 3'd0;
      lives_q       <= LW'(LIVES);
      move_cnt_q    <= '0;
      fire_cnt_q    <= '0;
      timer_q       <= '0;
      bullet_fire_q <= 1'b0;
      bullet_dir_q  <= DIR_LEFT;
      bullet_x_q    <= SPAWN_X + HALF;
      bullet_y_q    <= SPAWN_Y + HALF;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      dir_q         <= dir_d;
      st_q          <= st_d;
      rom_row_q     <= rom_row_d;
      rom_col_q     <= rom_col_d;
      lives_q       <= lives_d;
      move_cnt_q    <= move_cnt_d;
      fire_cnt_q    <= fire_cnt_d;
      timer_q       <= timer_d;
      bullet_fire_q <= bullet_fire_d;
      bullet_dir_q  <= bullet_dir_d;
      bullet_x_q    <= bullet_x_d;
      bullet_y_q    <= bullet_y_d;
    end
  end

  assign bullet_fire      = bullet_fire_q;
  assign bullet_direction = bullet_dir_q;
  assign bullet_x         = bullet_x_q;
  assign bullet_y         = bullet_y_q;
  assign pos_x            = pos_x_q;
  assign pos_y            = pos_y_q;
  assign lives            = lives_q;
  assign tank_state       = pack_state(2'(PLAYER_INDEX),
                                       (st_q == ST_ALIVE) || (st_q == ST_HIT),
                                       10'(pos_x_q), 10'(pos_y_q), dir_q,
                                       rom_row_q, rom_col_q);

endmodule

// File: tb/tb_tank_ctrl.sv
// Directed bench for tank_ctrl: stimulus schedules cycle-stamped expectations,
// a negedge monitor compares them and matches every bullet_fire pulse.
`timescale 1ns/1ps
module tb_tank_ctrl;

  localparam int TILE_W = 32;
  localparam int MAP_W  = 16;
  localparam int MAP_H  = 16;
  localparam int POS_W  = 10;
  localparam int LIVES  = 2;

  typedef enum {C_POSX, C_POSY, C_DIR, C_ROW, C_COL, C_LIVES, C_ACT, C_BF, C_BX, C_BY, C_STATE} chk_e;
  typedef struct { int at; chk_e kind; logic [31:0] val; } exp_t;
  typedef struct { int at; int bx; int by; int bdir; } fire_t;

  logic clk, reset, game_over, killed;
  logic [MAP_W*MAP_H-1:0] wall_map;
  logic up, down, left, right, fire;
  logic bullet_fire;
  logic [1:0] bullet_direction;
  logic [POS_W-1:0] bullet_x, bullet_y, pos_x, pos_y;
  logic [$clog2(LIVES+1)-1:0] lives;
  logic [31:0] tank_state;

  exp_t  exp_q[$];
  fire_t fire_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic drain = 1'b0;
  logic drained = 1'b0;
  logic [31:0] mon_act;
  fire_t mon_f;

  tank_ctrl #(
    .INIX(32), .INIY(32), .PLAYER_INDEX(1), .TILE_W(TILE_W), .MAP_W(MAP_W), .MAP_H(MAP_H),
    .POS_W(POS_W), .MOVE_TIME(4), .FIRE_TIME(8), .EXPLODE_TIME(16), .RESPAWN_TIME(20),
    .LIVES(LIVES), .ANIM_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .game_over(game_over), .killed(killed), .wall_map(wall_map),
    .up(up), .down(down), .left(left), .right(right), .fire(fire),
    .bullet_fire(bullet_fire), .bullet_direction(bullet_direction),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .pos_x(pos_x), .pos_y(pos_y),
    .lives(lives), .tank_state(tank_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input chk_e k);
    case (k)
      C_POSX:  return 32'(pos_x);
      C_POSY:  return 32'(pos_y);
      C_DIR:   return 32'(tank_state[7:6]);
      C_ROW:   return 32'(tank_state[5:3]);
      C_COL:   return 32'(tank_state[2:0]);
      C_LIVES: return 32'(lives);
      C_ACT:   return 32'(tank_state[28]);
      C_BF:    return 32'(bullet_fire);
      C_BX:    return 32'(bullet_x);
      C_BY:    return 32'(bullet_y);
      default: return tank_state;
    endcase
  endfunction

  function automatic string kind_name(input chk_e k);
    case (k)
      C_POSX:  return "pos_x";
      C_POSY:  return "pos_y";
      C_DIR:   return "dir";
      C_ROW:   return "rom_row";
      C_COL:   return "rom_col";
      C_LIVES: return "lives";
      C_ACT:   return "active";
      C_BF:    return "bullet_fire";
      C_BX:    return "bullet_x";
      C_BY:    return "bullet_y";
      default: return "tank_state";
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic u, input logic d, input logic l,
                                input logic r, input logic f, input logic k);
    up = u; down = d; left = l; right = r; fire = f; killed = k;
  endtask

  task automatic check_output(input int at, input chk_e k, input logic [31:0] v);
    exp_t e;
    e.at = at; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_fire(input int at, input int bx, input int by, input int bdir);
    fire_t f;
    f.at = at; f.bx = bx; f.by = by; f.bdir = bdir;
    fire_q.push_back(f);
  endtask

  // Monitor: compares expectations due this cycle and matches each launch pulse.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at <= cyc) begin
        mon_act = observe(exp_q[i].kind);
        checks++;
        if (exp_q[i].at != cyc || mon_act !== exp_q[i].val) begin
          errors++;
          $display("[TB] FAIL %s @%0d: got %0d, expected %0d (due cycle %0d)",
                   kind_name(exp_q[i].kind), cyc, mon_act, exp_q[i].val, exp_q[i].at);
        end
        exp_q.delete(i);
      end
    end
    if (bullet_fire === 1'b1) begin
      checks++;
      if (fire_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL fire @%0d: got unexpected launch, expected none", cyc);
      end else begin
        mon_f = fire_q.pop_front();
        if (mon_f.at != cyc || int'(bullet_x) != mon_f.bx || int'(bullet_y) != mon_f.by ||
            int'(bullet_direction) != mon_f.bdir) begin
          errors++;
          $display("[TB] FAIL fire @%0d: got x=%0d y=%0d dir=%0d, expected cyc=%0d x=%0d y=%0d dir=%0d",
                   cyc, bullet_x, bullet_y, bullet_direction, mon_f.at, mon_f.bx, mon_f.by, mon_f.bdir);
        end
      end
    end
    if (drain && !drained) begin
      foreach (exp_q[i]) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no sample, expected %0d at cycle %0d",
                 kind_name(exp_q[i].kind), exp_q[i].val, exp_q[i].at);
      end
      foreach (fire_q[i]) begin
        checks++;
        errors++;
        $display("[TB] FAIL fire: got no launch, expected one at cycle %0d", fire_q[i].at);
      end
      drained = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    for (int r = 0; r < MAP_H; r++)
      for (int c = 0; c < MAP_W; c++)
        wall_map[r*MAP_W+c] = (r == 0 || r == MAP_H-1 || c == 0 || c == MAP_W-1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    game_over = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    t = cyc;
    check_output(t+1, C_POSX, 32);
    check_output(t+1, C_POSY, 32);
    check_output(t+1, C_DIR, 0);
    check_output(t+1, C_LIVES, 2);
    check_output(t+1, C_ACT, 1);
    check_output(t+1, C_BF, 0);
    check_output(t+1, C_BX, 48);
    check_output(t+1, C_BY, 48);
    check_output(t+1, C_STATE, 32'h3080_2000);
    tick(2);

    // Blocked turns at spawn: up then left into the border walls.
    t = cyc;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output(t+1, C_DIR, 2);
    check_output(t+1, C_POSY, 32);
    check_output(t+1, C_ROW, 2);
    check_output(t+2, C_DIR, 0);
    check_output(t+5, C_POSX, 32);
    check_output(t+5, C_COL, 0);
    tick(1);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    tick(4);

    // Hold right for 40 cycles; first step is immediate since the move counter is 0.
    t = cyc;
    apply_stimulus(0, 0, 0, 1, 0, 0);
    check_output(t+1, C_POSX, 33);
    check_output(t+1, C_DIR, 1);
    check_output(t+1, C_COL, 1);
    check_output(t+4, C_POSX, 33);
    check_output(t+5, C_POSX, 34);
    check_output(t+5, C_COL, 0);
    check_output(t+40, C_POSX, 42);
    check_output(t+40, C_COL, 0);
    check_output(t+44, C_POSX, 42);
    tick(40);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(6);

    // Hold fire for 20 cycles at (42,32) facing right.
    t = cyc;
    apply_stimulus(0, 0, 0, 0, 1, 0);
    expect_fire(t+1, 58, 48, 1);
    expect_fire(t+9, 58, 48, 1);
    expect_fire(t+17, 58, 48, 1);
    check_output(t+2, C_BF, 0);
    check_output(t+25, C_BF, 0);
    tick(20);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(10);

    // Freeze mid-move with fire held, then resume from the held counters.
    t = cyc;
    apply_stimulus(0, 0, 0, 1, 1, 0);
    expect_fire(t+1, 59, 48, 1);
    check_output(t+1, C_POSX, 43);
    check_output(t+9, C_BF, 0);
    check_output(t+12, C_POSX, 43);
    check_output(t+14, C_POSX, 43);
    check_output(t+15, C_POSX, 44);
    expect_fire(t+19, 60, 48, 1);
    tick(2);
    game_over = 1'b1;
    tick(10);
    game_over = 1'b0;
    tick(4);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    tick(3);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(12);

    // First kill (with fire in the same cycle), explosion, respawn.
    t = cyc;
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output(t+1, C_LIVES, 1);
    check_output(t+1, C_ACT, 1);
    check_output(t+1, C_ROW, 4);
    check_output(t+1, C_COL, 0);
    check_output(t+1, C_BF, 0);
    check_output(t+5, C_COL, 1);
    check_output(t+13, C_COL, 3);
    check_output(t+16, C_ACT, 1);
    check_output(t+17, C_ACT, 0);
    check_output(t+20, C_LIVES, 1);
    check_output(t+30, C_POSX, 44);
    check_output(t+36, C_ACT, 0);
    check_output(t+37, C_ACT, 1);
    check_output(t+37, C_POSX, 32);
    check_output(t+37, C_POSY, 32);
    check_output(t+37, C_STATE, 32'h3080_2000);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(6);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(12);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    tick(10);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(12);

    // Second kill: last life, tank ends DEAD and ignores buttons.
    t = cyc;
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_output(t+1, C_LIVES, 0);
    check_output(t+16, C_ACT, 1);
    check_output(t+17, C_ACT, 0);
    check_output(t+30, C_BF, 0);
    check_output(t+60, C_ACT, 0);
    check_output(t+60, C_POSX, 32);
    check_output(t+60, C_POSY, 32);
    check_output(t+60, C_LIVES, 0);
    check_output(t+60, C_ROW, 4);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(20);
    apply_stimulus(1, 0, 0, 1, 1, 0);
    tick(40);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(2);

    // Reset out of DEAD, then reset again in the middle of HIT.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    t = cyc;
    check_output(t+1, C_LIVES, 2);
    check_output(t+1, C_ACT, 1);
    tick(2);
    t = cyc;
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_output(t+1, C_LIVES, 1);
    check_output(t+5, C_ROW, 4);
    check_output(t+5, C_COL, 1);
    check_output(t+6, C_LIVES, 2);
    check_output(t+6, C_ACT, 1);
    check_output(t+6, C_ROW, 0);
    check_output(t+6, C_COL, 0);
    check_output(t+6, C_POSX, 32);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);

    drain = 1'b1;
    wait (drained);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
